me_block_loader: RTL and testbench

- Upstream feeder and result collector for the full-search motion-estimation core.
- Accepts a byte stream of one 16x16 reference block, then one 32x32 search window, and stores both in internal pixel arrays.
- Serves the core's R/S1/S2 read ports and drives its start level.
- Captures bestDistance/motion vector on completed and presents them on a valid/ready result port tagged with a block index.

---
 rtl/me_pkg.sv | 33 +++
 rtl/me_pix_ram.sv | 40 ++++
 rtl/me_block_loader.sv | 193 +++++++++++++++++++
 tb/tb_me_block_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
`default_nettype none
// ============================================================================
// Module   : me_pkg
// Purpose  : Shared types and constants for the motion-estimation block
//            loader: pixel/array geometry, loader state encoding and the
//            captured core-result record.
// Revision : 1.0 - initial release
// ============================================================================
package me_pkg;

   localparam int PIX_W    = 8;     // pixel width in bits
   localparam int R_PIXELS = 256;   // 16x16 reference block
   localparam int S_PIXELS = 1024;  // 32x32 search window
   localparam int BLK_W    = 16;    // reference block edge length
   localparam int WIN_W    = 32;    // search window edge length

   typedef enum logic [1:0] {
      LOAD_R = 2'd0,
      LOAD_S = 2'd1,
      RUN    = 2'd2,
      FLUSH  = 2'd3
   } state_t;

   // Core result as captured on completion. The block tag width is a
   // parameter of the loader, so the tag is held next to this record.
   typedef struct packed {
      logic [7:0] distance;
      logic [3:0] mvx;
      logic [3:0] mvy;
   } result_t;

endpackage : me_pkg
`default_nettype wire

// File: rtl/me_pix_ram.sv
`default_nettype none
// ============================================================================
// Module   : me_pix_ram
// Purpose  : Pixel store with one synchronous write port and NRD
//            combinational read ports. Contents are never reset.
// Ports    : clock          - write clock, rising edge
//            we             - write enable
//            waddr / wdata  - write address / pixel
//            raddr          - NRD packed read addresses
//            rdata          - NRD packed read pixels (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module me_pix_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 256,
   parameter int NRD   = 1,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                      clock,
   input  logic                      we,
   input  logic [AW-1:0]             waddr,
   input  logic [WIDTH-1:0]          wdata,
   input  logic [NRD-1:0][AW-1:0]    raddr,
   output logic [NRD-1:0][WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      assign rdata[i] = r_mem[raddr[i]];
   end

endmodule : me_pix_ram
`default_nettype wire

// File: rtl/me_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : me_block_loader
// Purpose  : Feeds the full-search motion-estimation core. Loads a 16x16
//            reference block then a 32x32 search window from a byte stream,
//            serves the core's R/S1/S2 read ports, runs the core via start,
//            and returns best distance / motion vector on a valid/ready port.
// Ports    : clock, reset                 - clock / async active-high reset
//            in_valid/in_ready/in_data/in_last - pixel input stream
//            start, completed             - core run level / core done
//            bestDistance, motionX/Y      - core result
//            AddressR/S1/S2, R/S1/S2      - core pixel read ports
//            res_valid/res_ready/res_*    - tagged result output
//            busy                         - core run or flush in progress
//            err_framing                  - sticky in_last framing error
// Revision : 1.0 - initial release
// ============================================================================
module me_block_loader
   import me_pkg::*;
#(
   parameter int PIX_W    = 8,
   parameter int R_PIXELS = 256,
   parameter int S_PIXELS = 1024,
   parameter int BLK_ID_W = 8
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [PIX_W-1:0]    in_data,
   input  logic                in_last,
   output logic                start,
   input  logic                completed,
   input  logic [7:0]          bestDistance,
   input  logic [3:0]          motionX,
   input  logic [3:0]          motionY,
   input  logic [7:0]          AddressR,
   input  logic [9:0]          AddressS1,
   input  logic [9:0]          AddressS2,
   output logic [PIX_W-1:0]    R,
   output logic [PIX_W-1:0]    S1,
   output logic [PIX_W-1:0]    S2,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [7:0]          res_distance,
   output logic [3:0]          res_mvx,
   output logic [3:0]          res_mvy,
   output logic [BLK_ID_W-1:0] res_blk,
   output logic                busy,
   output logic                err_framing
);

   localparam int BEAT_W = $clog2(S_PIXELS);
   localparam int RAW    = $clog2(R_PIXELS);

   state_t                 r_state;
   state_t                 w_state_nx;
   logic [BEAT_W-1:0]      r_beat;
   logic                   r_start;
   logic                   r_res_valid;
   result_t                r_res;
   logic [BLK_ID_W-1:0]    r_res_blk;
   logic [BLK_ID_W-1:0]    r_blk_cnt;
   logic                   r_err;

   logic                   w_acc;
   logic                   w_r_done;
   logic                   w_final;
   logic                   w_capture;
   logic                   w_we_r;
   logic                   w_we_s;
   logic [1:0][PIX_W-1:0]  w_s_rd;

   assign in_ready  = (r_state == LOAD_R) || (r_state == LOAD_S);
   assign busy      = (r_state == RUN) || (r_state == FLUSH);
   assign w_acc     = in_valid && in_ready;
   assign w_r_done  = (r_state == LOAD_R) && (r_beat == BEAT_W'(R_PIXELS - 1));
   // Final beat of the whole load (global beat 1279): the only beat on
   // which in_last may be high.
   assign w_final   = (r_state == LOAD_S) && (r_beat == BEAT_W'(S_PIXELS - 1));
   // A held result blocks capture unless it leaves on this same edge; the
   // core stays frozen with completed high meanwhile.
   assign w_capture = (r_state == RUN) && completed && (!r_res_valid || res_ready);
   assign w_we_r    = w_acc && (r_state == LOAD_R);
   assign w_we_s    = w_acc && (r_state == LOAD_S);

   // ------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= LOAD_R;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         LOAD_R:  if (w_acc && w_r_done) w_state_nx = LOAD_S;
         LOAD_S:  if (w_acc && w_final)  w_state_nx = RUN;
         RUN:     if (w_capture)         w_state_nx = FLUSH;
         FLUSH:                          w_state_nx = LOAD_R;
         default:                        w_state_nx = LOAD_R;
      endcase
   end

   // ------------------------------------------------------------------
   // Beat counter, core start, result capture, framing check
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_beat      <= '0;
         r_start     <= 1'b0;
         r_res_valid <= 1'b0;
         r_res       <= '0;
         r_res_blk   <= '0;
         r_blk_cnt   <= '0;
         r_err       <= 1'b0;
      end else begin
         // Advance is by count alone; in_last only feeds the error flag.
         if (w_acc) begin
            if (w_r_done || w_final) begin
               r_beat <= '0;
            end else begin
               r_beat <= r_beat + BEAT_W'(1);
            end
            if (in_last != w_final) begin
               r_err <= 1'b1;
            end
         end

         // Registered from the next state so start is high in the very
         // first RUN cycle and low in FLUSH.
         r_start <= (w_state_nx == RUN);

         if (w_capture) begin
            r_res.distance <= bestDistance;
            r_res.mvx      <= motionX;
            r_res.mvy      <= motionY;
            r_res_blk      <= r_blk_cnt;
            r_blk_cnt      <= r_blk_cnt + BLK_ID_W'(1);
            r_res_valid    <= 1'b1;
         end else if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign start        = r_start;
   assign res_valid    = r_res_valid;
   assign res_distance = r_res.distance;
   assign res_mvx      = r_res.mvx;
   assign res_mvy      = r_res.mvy;
   assign res_blk      = r_res_blk;
   assign err_framing  = r_err;

   // ------------------------------------------------------------------
   // Pixel stores: only written while loading, so reads are stable for
   // the entire search.
   // ------------------------------------------------------------------
   me_pix_ram #(
      .WIDTH (PIX_W),
      .DEPTH (R_PIXELS),
      .NRD   (1)
   ) u_rmem (
      .clock (clock),
      .we    (w_we_r),
      .waddr (r_beat[RAW-1:0]),
      .wdata (in_data),
      .raddr (AddressR),
      .rdata (R)
   );

   me_pix_ram #(
      .WIDTH (PIX_W),
      .DEPTH (S_PIXELS),
      .NRD   (2)
   ) u_smem (
      .clock (clock),
      .we    (w_we_s),
      .waddr (r_beat),
      .wdata (in_data),
      .raddr ({AddressS2, AddressS1}),
      .rdata (w_s_rd)
   );

   assign S1 = w_s_rd[0];
   assign S2 = w_s_rd[1];

endmodule : me_block_loader
`default_nettype wire

// File: tb/tb_me_block_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_me_block_loader
// Purpose  : Self-checking bench for me_block_loader with a behavioural core
//            stub and a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_me_block_loader;

   localparam int CORE_LAT = 64;

   logic       clock = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;
   logic       start;
   logic       completed;
   logic [7:0] bestDistance;
   logic [3:0] motionX;
   logic [3:0] motionY;
   logic [7:0] AddressR;
   logic [9:0] AddressS1;
   logic [9:0] AddressS2;
   logic [7:0] R;
   logic [7:0] S1;
   logic [7:0] S2;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_distance;
   logic [3:0] res_mvx;
   logic [3:0] res_mvy;
   logic [7:0] res_blk;
   logic       busy;
   logic       err_framing;

   always #5 clock = ~clock;

   me_block_loader #(
      .PIX_W    (8),
      .R_PIXELS (256),
      .S_PIXELS (1024),
      .BLK_ID_W (8)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .start        (start),
      .completed    (completed),
      .bestDistance (bestDistance),
      .motionX      (motionX),
      .motionY      (motionY),
      .AddressR     (AddressR),
      .AddressS1    (AddressS1),
      .AddressS2    (AddressS2),
      .R            (R),
      .S1           (S1),
      .S2           (S2),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_distance (res_distance),
      .res_mvx      (res_mvx),
      .res_mvy      (res_mvy),
      .res_blk      (res_blk),
      .busy         (busy),
      .err_framing  (err_framing)
   );

   // Core stub: counts while start is high, then holds completed until
   // start drops.
   int core_cnt;
   always @(posedge clock or posedge reset) begin
      if (reset)                  core_cnt <= 0;
      else if (!start)            core_cnt <= 0;
      else if (core_cnt < CORE_LAT) core_cnt <= core_cnt + 1;
   end
   assign completed = (core_cnt == CORE_LAT);

   typedef struct {
      logic [7:0] d;
      logic [3:0] x;
      logic [3:0] y;
      logic [7:0] b;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] exp_blk;
   logic [7:0] exp_r [256];
   logic [7:0] exp_s [1024];
   int         n_checks = 0;
   int         n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] pix(input int seed, input int k);
      int v;
      if (seed == 0) v = k;
      else           v = k * seed * 7 + seed * 13 + (k >> 3);
      return v[7:0];
   endfunction

   task automatic push_exp(input logic [7:0] d, input logic [3:0] x, input logic [3:0] y);
      exp_t e;
      bestDistance = d;
      motionX      = x;
      motionY      = y;
      e.d = d; e.x = x; e.y = y; e.b = exp_blk;
      sb.push_back(e);
      exp_blk = exp_blk + 8'd1;
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      chk({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_distance"}, 32'(res_distance), 32'(e.d));
         chk({tag, "_mvx"},      32'(res_mvx),      32'(e.x));
         chk({tag, "_mvy"},      32'(res_mvy),      32'(e.y));
         chk({tag, "_blk"},      32'(res_blk),      32'(e.b));
      end
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clock);
         t++;
      end
      if (t == 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic wait_completed();
      int t = 0;
      while (!completed && t < 500) begin
         @(negedge clock);
         t++;
      end
      chk("completed_seen", 32'(completed), 32'd1);
   endtask

   // Drives beats 0..nbeats-1; pixel k < 256 goes to R, the rest to S.
   task automatic load_block(input int seed, input int nbeats, input int bad_beat,
                             input bit drop_last, input bit gaps, input bit pre_final);
      for (int k = 0; k < nbeats; k++) begin
         wait_ready();
         if (gaps && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            in_last  = 1'b1;
            @(negedge clock);
         end
         if (pre_final && k == 1279) begin
            chk("pre_final_start",    32'(start),    32'd0);
            chk("pre_final_in_ready", 32'(in_ready), 32'd1);
         end
         in_valid = 1'b1;
         in_data  = pix(seed, k);
         in_last  = ((k == 1279) && !drop_last) || (k == bad_beat);
         if (k < 256) exp_r[k] = in_data;
         else         exp_s[k - 256] = in_data;
         @(negedge clock);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_reads(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         AddressR  = 8'($urandom_range(0, 255));
         AddressS1 = 10'($urandom_range(0, 1023));
         AddressS2 = 10'($urandom_range(0, 1023));
         #1;
         chk({tag, "_R"},  32'(R),  32'(exp_r[AddressR]));
         chk({tag, "_S1"}, 32'(S1), 32'(exp_s[AddressS1]));
         chk({tag, "_S2"}, 32'(S2), 32'(exp_s[AddressS2]));
         @(negedge clock);
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      sb.delete();
      exp_blk = 8'd0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b1;
      in_valid     = 1'b0;
      in_data      = 8'h00;
      in_last      = 1'b0;
      res_ready    = 1'b1;
      bestDistance = 8'h00;
      motionX      = 4'h0;
      motionY      = 4'h0;
      AddressR     = 8'h00;
      AddressS1    = 10'h000;
      AddressS2    = 10'h000;
      exp_blk      = 8'd0;

      // ---------------- reset state ----------------
      repeat (3) @(negedge clock);
      chk("rst_start",     32'(start),        32'd0);
      chk("rst_res_valid", 32'(res_valid),    32'd0);
      chk("rst_in_ready",  32'(in_ready),     32'd1);
      chk("rst_busy",      32'(busy),         32'd0);
      chk("rst_err",       32'(err_framing),  32'd0);
      chk("rst_res_blk",   32'(res_blk),      32'd0);
      chk("rst_res_dist",  32'(res_distance), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // ---------------- T1: basic load, run, capture ----------------
      push_exp(8'h12, 4'h3, 4'hC);
      load_block(0, 1280, -1, 1'b0, 1'b0, 1'b1);
      chk("t1_start",    32'(start),    32'd1);
      chk("t1_in_ready", 32'(in_ready), 32'd0);
      chk("t1_busy",     32'(busy),     32'd1);
      AddressR = 8'h05; AddressS1 = 10'h3FF; AddressS2 = 10'h120;
      #1;
      chk("t1_R_05",   32'(R),  32'h05);
      chk("t1_S1_3FF", 32'(S1), 32'hFF);
      chk("t1_S2_120", 32'(S2), 32'h20);
      @(negedge clock);
      check_reads(6, "t1_rd");
      wait_completed();
      @(negedge clock);
      check_result("t1_res");
      chk("t1_flush_start", 32'(start),    32'd0);
      chk("t1_flush_busy",  32'(busy),     32'd1);
      @(negedge clock);
      chk("t1_after_in_ready",  32'(in_ready),  32'd1);
      chk("t1_after_res_valid", 32'(res_valid), 32'd0);
      chk("t1_after_err",       32'(err_framing), 32'd0);

      // ---------------- T2: back-pressure across two blocks ----------------
      apply_reset();
      res_ready = 1'b0;
      push_exp(8'h40, 4'h7, 4'h1);
      load_block(3, 1280, -1, 1'b0, 1'b0, 1'b0);
      wait_completed();
      @(negedge clock);
      chk("t2_first_valid", 32'(res_valid), 32'd1);
      chk("t2_first_start", 32'(start),     32'd0);
      push_exp(8'h9A, 4'hE, 4'h5);
      load_block(5, 1280, -1, 1'b0, 1'b0, 1'b0);
      check_reads(3, "t2_rd");
      wait_completed();
      repeat (3) @(negedge clock);
      chk("t2_stall_start",    32'(start),    32'd1);
      chk("t2_stall_in_ready", 32'(in_ready), 32'd0);
      chk("t2_stall_busy",     32'(busy),     32'd1);
      check_result("t2_held");
      res_ready = 1'b1;
      @(negedge clock);
      check_result("t2_second");
      @(negedge clock);
      @(negedge clock);
      chk("t2_drain_valid",    32'(res_valid), 32'd0);
      chk("t2_drain_in_ready", 32'(in_ready),  32'd1);

      // ---------------- T3: framing errors ----------------
      push_exp(8'h77, 4'h2, 4'h9);
      load_block(7, 1280, 100, 1'b1, 1'b0, 1'b0);
      chk("t3_err",   32'(err_framing), 32'd1);
      chk("t3_start", 32'(start),       32'd1);
      check_reads(3, "t3_rd");
      wait_completed();
      @(negedge clock);
      check_result("t3_res");
      repeat (2) @(negedge clock);
      chk("t3_err_sticky", 32'(err_framing), 32'd1);

      // ---------------- T4a: reset in LOAD_S ----------------
      load_block(9, 701, -1, 1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      #1;
      chk("t4a_start",    32'(start),       32'd0);
      chk("t4a_in_ready", 32'(in_ready),    32'd1);
      chk("t4a_err",      32'(err_framing), 32'd0);
      chk("t4a_valid",    32'(res_valid),   32'd0);
      @(negedge clock);
      apply_reset();

      // ---------------- T4b: reset in RUN with a held result ----------------
      res_ready = 1'b0;
      push_exp(8'h31, 4'h4, 4'h4);
      load_block(11, 1280, -1, 1'b0, 1'b0, 1'b0);
      wait_completed();
      @(negedge clock);
      check_result("t4b_held");
      load_block(13, 1280, -1, 1'b0, 1'b0, 1'b0);
      chk("t4b_run_start", 32'(start), 32'd1);
      repeat (10) @(negedge clock);
      reset = 1'b1;
      #1;
      chk("t4b_start",    32'(start),        32'd0);
      chk("t4b_valid",    32'(res_valid),    32'd0);
      chk("t4b_blk",      32'(res_blk),      32'd0);
      chk("t4b_dist",     32'(res_distance), 32'd0);
      chk("t4b_in_ready", 32'(in_ready),     32'd1);
      chk("t4b_busy",     32'(busy),         32'd0);
      @(negedge clock);
      apply_reset();

      // ---------------- T5: gappy fresh load ----------------
      res_ready = 1'b1;
      push_exp(8'hC3, 4'hA, 4'h6);
      load_block(21, 1280, -1, 1'b0, 1'b1, 1'b1);
      chk("t5_start", 32'(start),       32'd1);
      chk("t5_err",   32'(err_framing), 32'd0);
      check_reads(16, "t5_rd");
      wait_completed();
      @(negedge clock);
      check_result("t5_res");
      @(negedge clock);
      chk("t5_after_in_ready", 32'(in_ready), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_me_block_loader
`default_nettype wire
